// File: rtl/ram_pkg.sv
// Shared sizing and word/address types for the simple_ram storage block.
package ram_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/simple_ram.sv
// Single-port synchronous RAM with a registered read port.
// Writes never update dout; reads land one edge after addr is sampled.
module simple_ram #(
  parameter int DATA_W = ram_pkg::DATA_W,
  parameter int ADDR_W = ram_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  input  logic [ADDR_W-1:0] addr,
  input  logic              ce,
  input  logic              we
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_wr;
  logic              w_rd;

  assign w_wr = ce & we;
  assign w_rd = ce & ~we;

  // Whole array clears on reset so every word reads back zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[addr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    dout <= '0;
    else if (w_rd) dout <= r_mem[addr];
  end
endmodule

// File: tb/tb_simple_ram.sv
// Directed bench for simple_ram: stimulus pushes expected dout per edge,
// a monitor pops and compares one half-cycle later.
module tb_simple_ram;
  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic [7:0] dout;
  logic [7:0] addr;
  logic       ce;
  logic       we;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] exp_q [$];

  simple_ram #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .dout(dout),
    .addr(addr), .ce(ce), .we(we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  // One access per edge; exp is the hand-derived dout after that edge.
  task automatic op(input logic c, input logic w, input logic [7:0] a,
                    input logic [7:0] d, input logic [7:0] exp);
    @(negedge clk);
    ce = c; we = w; addr = a; din = d;
    @(posedge clk);
    exp_q.push_back(exp);
  endtask

  task automatic drain();
    @(negedge clk);
    ce = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("dout", dout, e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] av;
    rst_n = 1'b0; ce = 1'b0; we = 1'b0; addr = '0; din = '0;
    repeat (2) @(negedge clk);
    check("reset_dout", dout, 8'h00);
    rst_n = 1'b1;

    // Preload something so the mid-run reset has visible effect.
    op(1, 1, 8'h7F, 8'h55, 8'h00);
    op(1, 0, 8'h7F, 8'h00, 8'h55);
    drain();

    // 1. Mid-run async reset clears dout immediately; accesses ignored during it.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_dout", dout, 8'h00);
    op(1, 1, 8'h00, 8'hAA, 8'h00);
    op(1, 0, 8'h7F, 8'h00, 8'h00);
    drain();
    rst_n = 1'b1;
    op(1, 0, 8'h00, 8'h00, 8'h00);
    op(1, 0, 8'h7F, 8'h00, 8'h00);
    op(1, 0, 8'hFF, 8'h00, 8'h00);

    // 2. Write holds dout; read returns after one edge.
    op(1, 0, 8'h7F, 8'h00, 8'h00);
    op(1, 1, 8'h7F, 8'h99, 8'h00);
    op(1, 1, 8'h10, 8'hA5, 8'h00);
    op(1, 0, 8'h10, 8'h00, 8'hA5);

    // 3. ce=0 blocks the write and dout holds.
    op(0, 1, 8'h10, 8'h3C, 8'hA5);
    op(0, 0, 8'h11, 8'h00, 8'hA5);
    op(1, 0, 8'h7F, 8'h00, 8'h99);
    op(1, 0, 8'h10, 8'h00, 8'hA5);

    // 4. Address boundaries, no aliasing.
    op(1, 1, 8'h00, 8'h01, 8'hA5);
    op(1, 1, 8'hFF, 8'hFE, 8'hA5);
    op(1, 0, 8'h00, 8'h00, 8'h01);
    op(1, 0, 8'hFF, 8'h00, 8'hFE);

    // 5. Full sweep of addr^5A.
    for (int a = 0; a < 256; a++) begin
      av = 8'(a);
      op(1, 1, av, av ^ 8'h5A, 8'hFE);
    end
    for (int a = 0; a < 256; a++) begin
      av = 8'(a);
      op(1, 0, av, 8'h00, av ^ 8'h5A);
    end

    // 6. Back-to-back write then read, then alternating R/W every cycle.
    op(1, 1, 8'h20, 8'h77, 8'hA5);
    op(1, 0, 8'h20, 8'h00, 8'h77);
    op(1, 1, 8'h21, 8'h11, 8'h77);
    op(1, 0, 8'h21, 8'h00, 8'h11);
    op(1, 1, 8'h22, 8'h22, 8'h11);
    op(1, 0, 8'h20, 8'h00, 8'h77);
    op(1, 1, 8'h20, 8'hC3, 8'h77);
    op(1, 0, 8'h22, 8'h00, 8'h22);
    op(1, 0, 8'h20, 8'h00, 8'hC3);
    drain();

    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
